// File: rtl/i2c_cmd_sequencer.sv
// Command FIFO plus one-transaction-at-a-time sequencer driving the i2c_master control pins.
// Define I2C_SEQ_TIMEOUT_EN to enable the WAIT_BUSY/WAIT_DONE timeout and rsp_err.
module i2c_cmd_sequencer #(
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [ADDR_W-1:0]        cmd_addr,
  input  logic                     cmd_rd_wr,
  input  logic [DATA_W-1:0]        cmd_data,
  output logic                     rsp_valid,
  output logic [DATA_W-1:0]        rsp_data,
  output logic                     rsp_err,
  output logic [ADDR_W-1:0]        m_address,
  output logic [DATA_W-1:0]        m_din,
  output logic                     m_rd_wr,
  output logic                     m_start,
  output logic                     m_stop,
  input  logic                     m_busy,
  input  logic [DATA_W-1:0]        m_dout,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     idle
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE,
    STOP,
    RESP
  } state_t;

  state_t state, state_next;

  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [DEPTH-1:0]  mem_rd_wr;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [LVL_W-1:0]  count;
  logic              full, empty, push, pop;
  logic              tmo_hit, tmo_fire, done_fire;

  assign full       = (count == LVL_W'(DEPTH));
  assign empty      = (count == '0);
  assign push       = cmd_valid && !full;
  assign pop        = (state == IDLE) && !empty;
  assign cmd_ready  = !full;
  assign fifo_level = count;
  assign idle       = (state == IDLE) && empty;

  assign done_fire = (state == WAIT_DONE) && !m_busy;
  assign tmo_fire  = tmo_hit && (((state == WAIT_BUSY) && !m_busy) ||
                                 ((state == WAIT_DONE) && m_busy));

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr]  <= cmd_addr;
      mem_data[wr_ptr]  <= cmd_data;
      mem_rd_wr[wr_ptr] <= cmd_rd_wr;
    end
  end

  // Full blocks push even when a pop happens the same cycle, so level never overshoots DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + LVL_W'(1);
        2'b01:   count <= count - LVL_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    m_start    = 1'b0;
    m_stop     = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      IDLE:      if (!empty) state_next = START;
      START: begin
        m_start    = 1'b1;
        state_next = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (m_busy)       state_next = WAIT_DONE;
        else if (tmo_hit) state_next = STOP;
      end
      WAIT_DONE: begin
        if (!m_busy || tmo_hit) state_next = STOP;
      end
      STOP: begin
        m_stop     = 1'b1;
        state_next = RESP;
      end
      RESP: begin
        rsp_valid  = 1'b1;
        state_next = IDLE;
      end
      default:   state_next = IDLE;
    endcase
  end

  // Master-side fields are loaded only on pop, so they stay put from START through STOP.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_address <= '0;
      m_din     <= '0;
      m_rd_wr   <= 1'b0;
      rsp_data  <= '0;
    end else begin
      if (pop) begin
        m_address <= mem_addr[rd_ptr];
        m_din     <= mem_data[rd_ptr];
        m_rd_wr   <= mem_rd_wr[rd_ptr];
      end
      if (done_fire)     rsp_data <= m_rd_wr ? m_dout : '0;
      else if (tmo_fire) rsp_data <= '0;
    end
  end

`ifdef I2C_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] tmo_cnt;
  logic             err_q;

  assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT - 1));
  assign rsp_err = err_q;

  // Counter restarts on entry to each wait state; tmo_hit marks the last allowed wait cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if ((state == START) || ((state == WAIT_BUSY) && m_busy)) begin
      tmo_cnt <= '0;
    end else if (((state == WAIT_BUSY) || (state == WAIT_DONE)) && !tmo_hit) begin
      tmo_cnt <= tmo_cnt + CNT_W'(1);
    end else begin
      tmo_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)          err_q <= 1'b0;
    else if (tmo_fire)  err_q <= 1'b1;
    else if (done_fire) err_q <= 1'b0;
  end
`else
  assign tmo_hit = 1'b0;
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Self-checking bench for i2c_cmd_sequencer: table-driven transactions against a behavioural
// master model, plus directed FIFO-full, push/pop, reset and (with I2C_SEQ_TIMEOUT_EN) timeout cases.
module tb_i2c_cmd_sequencer;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int TMO    = 16;
`ifdef I2C_SEQ_TIMEOUT_EN
  localparam int LONG_BUSY = 12;
`else
  localparam int LONG_BUSY = 20;
`endif
  localparam int WAIT_LIMIT = 400;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic              cmd_rd_wr = 1'b0;
  logic [DATA_W-1:0] cmd_data = '0;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic [ADDR_W-1:0] m_address;
  logic [DATA_W-1:0] m_din;
  logic              m_rd_wr;
  logic              m_start;
  logic              m_stop;
  logic              m_busy = 1'b0;
  logic [DATA_W-1:0] m_dout = '0;
  logic [$clog2(DEPTH):0] fifo_level;
  logic              idle;

  i2c_cmd_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_rd_wr(cmd_rd_wr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .m_address(m_address), .m_din(m_din), .m_rd_wr(m_rd_wr),
    .m_start(m_start), .m_stop(m_stop), .m_busy(m_busy), .m_dout(m_dout),
    .fifo_level(fifo_level), .idle(idle)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic              rd_wr;
    int                cyc;
  } start_t;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              err;
    int                cyc;
  } rsp_t;

  start_t start_q[$];
  rsp_t   rsp_q[$];
  int     stop_cnt = 0;
  int     stop_cyc = 0;
  logic [ADDR_W-1:0] stop_addr = '0;
  logic [DATA_W-1:0] stop_din = '0;
  logic              stop_rw = 1'b0;

  // Record every control pulse seen by the master with the cycle it occupied.
  always @(negedge clk) begin
    if (m_start) start_q.push_back('{m_address, m_din, m_rd_wr, cyc});
    if (m_stop) begin
      stop_cnt++;
      stop_cyc  = cyc;
      stop_addr = m_address;
      stop_din  = m_din;
      stop_rw   = m_rd_wr;
    end
    if (rsp_valid) rsp_q.push_back('{rsp_data, rsp_err, cyc});
  end

  // Master model: busy rises two cycles after start, stays high model_len cycles, dout set at fall.
  logic              model_en   = 1'b1;
  int                model_len  = 4;
  logic [DATA_W-1:0] model_dout = '0;
  int                fall_cyc   = 0;

  always begin
    @(negedge clk);
    if (model_en && m_start && !reset) begin
      repeat (2) @(negedge clk);
      m_busy = 1'b1;
      repeat (model_len) @(negedge clk);
      m_dout   = model_dout;
      m_busy   = 1'b0;
      fall_cyc = cyc;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got time %0t required < 200000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_cmd_ready"},  32'(cmd_ready),  32'd1);
    checkOutput({tag, "_rsp_valid"},  32'(rsp_valid),  32'd0);
    checkOutput({tag, "_rsp_data"},   32'(rsp_data),   32'd0);
    checkOutput({tag, "_rsp_err"},    32'(rsp_err),    32'd0);
    checkOutput({tag, "_m_address"},  32'(m_address),  32'd0);
    checkOutput({tag, "_m_din"},      32'(m_din),      32'd0);
    checkOutput({tag, "_m_rd_wr"},    32'(m_rd_wr),    32'd0);
    checkOutput({tag, "_m_start"},    32'(m_start),    32'd0);
    checkOutput({tag, "_m_stop"},     32'(m_stop),     32'd0);
    checkOutput({tag, "_fifo_level"}, 32'(fifo_level), 32'd0);
    checkOutput({tag, "_idle"},       32'(idle),       32'd1);
  endtask

  // Called just after a falling edge; returns just after the falling edge following the push edge.
  task automatic pushCmd(input logic [ADDR_W-1:0] a, input logic rw, input logic [DATA_W-1:0] d,
                         output int push_cyc);
    int k;
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_rd_wr = rw;
    cmd_data  = d;
    for (k = 0; k < WAIT_LIMIT; k++) begin
      if (cmd_ready) break;
      @(negedge clk); #1;
    end
    if (k == WAIT_LIMIT) checkOutput("push_accept_timeout", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    @(negedge clk); #1;
    push_cyc  = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic waitRsp(input int n, input string name);
    for (int k = 0; k < WAIT_LIMIT; k++) begin
      if (rsp_q.size() >= n) break;
      @(negedge clk); #1;
    end
    checkOutput({name, "_rsp_arrived"}, 32'(rsp_q.size() >= n), 32'd1);
  endtask

  task automatic waitStart(input int n, input string name);
    for (int k = 0; k < WAIT_LIMIT; k++) begin
      if (start_q.size() >= n) break;
      @(negedge clk); #1;
    end
    checkOutput({name, "_start_seen"}, 32'(start_q.size() >= n), 32'd1);
  endtask

  typedef struct {
    string             name;
    logic [ADDR_W-1:0] addr;
    logic              rd_wr;
    logic [DATA_W-1:0] din;
    int                busy_len;
    logic [DATA_W-1:0] slave_dout;
    logic [DATA_W-1:0] exp_data;
  } vec_t;

  vec_t vecs[5];
  int   v_start0, v_rsp0, v_stop0, v_push;

  task automatic applyStimulus(input vec_t v);
    model_len  = v.busy_len;
    model_dout = v.slave_dout;
    v_start0   = start_q.size();
    v_rsp0     = rsp_q.size();
    v_stop0    = stop_cnt;
    pushCmd(v.addr, v.rd_wr, v.din, v_push);
    waitRsp(v_rsp0 + 1, v.name);
  endtask

  int base_s, base_r, base_stop, pc, pc5, r_cyc;

  initial begin
    vecs[0] = '{"wr50",  7'h50, 1'b0, 8'hA5, LONG_BUSY, 8'h77, 8'h00};
    vecs[1] = '{"rd3c",  7'h3C, 1'b1, 8'h00, LONG_BUSY, 8'h5A, 8'h5A};
    vecs[2] = '{"wr00",  7'h00, 1'b0, 8'hFF, 3,         8'hC3, 8'h00};
    vecs[3] = '{"rd01",  7'h01, 1'b1, 8'h12, 5,         8'h00, 8'h00};
    vecs[4] = '{"rd7f",  7'h7F, 1'b1, 8'h00, 1,         8'hFF, 8'hFF};

    $display("[TB] reset");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk); #1;
    checkResetState("reset");

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i]);
      checkOutput({vecs[i].name, "_n_start"}, 32'(start_q.size() - v_start0), 32'd1);
      if (start_q.size() > v_start0) begin
        checkOutput({vecs[i].name, "_m_address"}, 32'(start_q[v_start0].addr), 32'(vecs[i].addr));
        checkOutput({vecs[i].name, "_m_din"},     32'(start_q[v_start0].din),  32'(vecs[i].din));
        checkOutput({vecs[i].name, "_m_rd_wr"},   32'(start_q[v_start0].rd_wr), 32'(vecs[i].rd_wr));
        checkOutput({vecs[i].name, "_start_lat"}, 32'(start_q[v_start0].cyc), 32'(v_push + 1));
      end
      checkOutput({vecs[i].name, "_n_stop"},    32'(stop_cnt - v_stop0), 32'd1);
      checkOutput({vecs[i].name, "_stop_addr"}, 32'(stop_addr), 32'(vecs[i].addr));
      checkOutput({vecs[i].name, "_stop_din"},  32'(stop_din),  32'(vecs[i].din));
      checkOutput({vecs[i].name, "_stop_rw"},   32'(stop_rw),   32'(vecs[i].rd_wr));
      checkOutput({vecs[i].name, "_stop_lat"},  32'(stop_cyc),  32'(fall_cyc + 1));
      if (rsp_q.size() > v_rsp0) begin
        checkOutput({vecs[i].name, "_rsp_data"}, 32'(rsp_q[v_rsp0].data), 32'(vecs[i].exp_data));
        checkOutput({vecs[i].name, "_rsp_err"},  32'(rsp_q[v_rsp0].err),  32'd0);
        checkOutput({vecs[i].name, "_rsp_lat"},  32'(rsp_q[v_rsp0].cyc),  32'(fall_cyc + 2));
      end
    end

    // Reset while WAIT_DONE with two commands queued: nothing survives and no stop/response.
    $display("[TB] reset mid-transaction");
    model_len  = 30;
    model_dout = 8'h99;
    base_s = start_q.size();
    pushCmd(7'h33, 1'b1, 8'h00, pc);
    waitStart(base_s + 1, "rst");
    for (int k = 0; k < WAIT_LIMIT && !m_busy; k++) begin
      @(negedge clk); #1;
    end
    repeat (3) begin @(negedge clk); #1; end
    pushCmd(7'h44, 1'b0, 8'h44, pc);
    pushCmd(7'h45, 1'b0, 8'h45, pc);
    checkOutput("rst_pre_level", 32'(fifo_level), 32'd2);
    base_s = start_q.size();
    base_r = rsp_q.size();
    base_stop = stop_cnt;
    reset = 1'b1;
    @(negedge clk); #1;
    checkResetState("rst_mid");
    reset = 1'b0;
    repeat (40) begin @(negedge clk); #1; end
    checkOutput("rst_no_rsp",   32'(rsp_q.size() - base_r), 32'd0);
    checkOutput("rst_no_stop",  32'(stop_cnt - base_stop),  32'd0);
    checkOutput("rst_no_start", 32'(start_q.size() - base_s), 32'd0);
    checkOutput("rst_idle",     32'(idle), 32'd1);

    // FIFO full: four commands fill the FIFO behind an in-flight one; the fifth waits for a pop.
    $display("[TB] fifo full");
    model_len  = 10;
    model_dout = 8'h00;
    base_s = start_q.size();
    base_r = rsp_q.size();
    pushCmd(7'h10, 1'b0, 8'h01, pc);
    waitStart(base_s + 1, "full");
    for (int i = 1; i <= 4; i++) pushCmd(7'(8'h10 + i), 1'b0, 8'(i + 1), pc);
    checkOutput("full_ready", 32'(cmd_ready), 32'd0);
    checkOutput("full_level", 32'(fifo_level), 32'd4);
    pushCmd(7'h15, 1'b0, 8'h06, pc5);
    waitRsp(base_r + 6, "full");
    repeat (20) begin @(negedge clk); #1; end
    checkOutput("full_n_rsp", 32'(rsp_q.size() - base_r), 32'd6);
    checkOutput("full_n_start", 32'(start_q.size() - base_s), 32'd6);
    if (start_q.size() >= base_s + 6) begin
      for (int i = 0; i < 6; i++)
        checkOutput($sformatf("full_order%0d", i), 32'(start_q[base_s + i].addr), 32'(8'h10 + i));
      checkOutput("full_5th_after_pop", 32'(pc5), 32'(start_q[base_s + 1].cyc + 1));
    end

    // Push and pop on the same edge at level 2.
    $display("[TB] push and pop together");
    model_len = 8;
    base_s = start_q.size();
    base_r = rsp_q.size();
    pushCmd(7'h60, 1'b0, 8'h60, pc);
    waitStart(base_s + 1, "pp");
    pushCmd(7'h61, 1'b0, 8'h61, pc);
    pushCmd(7'h62, 1'b0, 8'h62, pc);
    waitRsp(base_r + 1, "pp_first");
    r_cyc = (rsp_q.size() > base_r) ? rsp_q[base_r].cyc : 0;
    @(negedge clk); #1;
    checkOutput("pp_level_before", 32'(fifo_level), 32'd2);
    pushCmd(7'h63, 1'b0, 8'h63, pc);
    checkOutput("pp_push_cyc", 32'(pc), 32'(r_cyc + 2));
    checkOutput("pp_level_after", 32'(fifo_level), 32'd2);
    waitRsp(base_r + 4, "pp_all");
    repeat (20) begin @(negedge clk); #1; end
    checkOutput("pp_n_start", 32'(start_q.size() - base_s), 32'd4);
    if (start_q.size() >= base_s + 4) begin
      checkOutput("pp_pop_cyc", 32'(start_q[base_s + 1].cyc), 32'(pc));
      for (int i = 0; i < 4; i++)
        checkOutput($sformatf("pp_order%0d", i), 32'(start_q[base_s + i].addr), 32'(8'h60 + i));
    end

`ifdef I2C_SEQ_TIMEOUT_EN
    // Master never answers: after TMO cycles in WAIT_BUSY a stop and an error response follow.
    $display("[TB] timeout");
    model_en = 1'b0;
    base_s = start_q.size();
    base_r = rsp_q.size();
    base_stop = stop_cnt;
    pushCmd(7'h22, 1'b1, 8'h00, pc);
    waitRsp(base_r + 1, "tmo");
    checkOutput("tmo_n_stop", 32'(stop_cnt - base_stop), 32'd1);
    if (rsp_q.size() > base_r && start_q.size() > base_s) begin
      checkOutput("tmo_err",      32'(rsp_q[base_r].err),  32'd1);
      checkOutput("tmo_data",     32'(rsp_q[base_r].data), 32'd0);
      checkOutput("tmo_stop_cyc", 32'(stop_cyc), 32'(start_q[base_s].cyc + TMO + 1));
      checkOutput("tmo_rsp_cyc",  32'(rsp_q[base_r].cyc), 32'(start_q[base_s].cyc + TMO + 2));
    end
    model_en   = 1'b1;
    model_len  = 5;
    model_dout = 8'h3D;
    pushCmd(7'h23, 1'b1, 8'h00, pc);
    waitRsp(base_r + 2, "tmo_next");
    if (rsp_q.size() > base_r + 1) begin
      checkOutput("tmo_next_err",  32'(rsp_q[base_r + 1].err),  32'd0);
      checkOutput("tmo_next_data", 32'(rsp_q[base_r + 1].data), 32'h3D);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
